// File: rtl/helo_pkg.sv
// helo_pkg: shared types and constants for the HELLO scroller.
//   char_t     - 3-bit character code (1xx = blank)
//   CODE_*     - character codes for H, E, L, O and blank
//   NUM_CHARS  - message length
//   MESSAGE    - the message H,E,L,L,O indexed 0..4
//   SEG_*      - active-low seven-segment patterns, bit order [0:6] = a..g
//   msg_char   - safe message lookup (out-of-range index gives blank)
//   rot_idx    - (base + off) mod 5 for base, off in 0..4
//   next_sel   - one rotation step forward or backward, wrapping 0..4
package helo_pkg;

  typedef logic [2:0] char_t;

  localparam char_t CODE_H     = 3'b000;
  localparam char_t CODE_E     = 3'b001;
  localparam char_t CODE_L     = 3'b010;
  localparam char_t CODE_O     = 3'b011;
  localparam char_t CODE_BLANK = 3'b100;

  localparam int unsigned NUM_CHARS = 5;

  localparam char_t MESSAGE [NUM_CHARS] = '{CODE_H, CODE_E, CODE_L, CODE_L, CODE_O};

  localparam logic [0:6] SEG_H     = 7'b1001000;
  localparam logic [0:6] SEG_E     = 7'b0110000;
  localparam logic [0:6] SEG_L     = 7'b1110001;
  localparam logic [0:6] SEG_O     = 7'b0000001;
  localparam logic [0:6] SEG_BLANK = 7'b1111111;

  function automatic char_t msg_char(input logic [2:0] idx);
    char_t c;
    c = CODE_BLANK;
    if (idx < 3'd5) c = MESSAGE[idx];
    return c;
  endfunction

  function automatic logic [2:0] rot_idx(input logic [2:0] base, input logic [2:0] off);
    logic [3:0] s;
    s = {1'b0, base} + {1'b0, off};
    if (s >= 4'd5) s = s - 4'd5;
    return s[2:0];
  endfunction

  function automatic logic [2:0] next_sel(input logic [2:0] cur, input logic rev);
    logic [2:0] n;
    if (rev) begin
      n = (cur == 3'd0 || cur > 3'd4) ? 3'd4 : cur - 3'd1;
    end else begin
      n = (cur >= 3'd4) ? 3'd0 : cur + 3'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/helo_seg_decoder.sv
// helo_seg_decoder: character code to active-low seven-segment pattern.
//   code - 3-bit character code (char_t); any 1xx code is blank
//   seg  - segments [0:6] = a..g, active-low
module helo_seg_decoder
  import helo_pkg::*;
(
  input  char_t      code,
  output logic [0:6] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code)
      CODE_H:  seg = SEG_H;
      CODE_E:  seg = SEG_E;
      CODE_L:  seg = SEG_L;
      CODE_O:  seg = SEG_O;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/helo_scroll_ctrl.sv
// helo_scroll_ctrl: rotates "HELLO" across five seven-segment digits.
//   DIV        - clocks per automatic scroll step (>= 2)
//   CLOCK_50   - clock, all state on rising edge
//   reset      - synchronous active-high reset
//   run        - 1 = auto-scroll, 0 = paused
//   step       - manual advance (rising edge, honoured only while paused)
//   dir        - 0 forward, 1 reverse; exists only with SCROLL_DIR_EN defined
//   sel        - registered rotation index 0..4
//   HEX4..HEX0 - active-low digits, [0:6] = a..g; HEXk shows C[(sel+4-k) mod 5]
// Optional feature macro: SCROLL_DIR_EN (adds the dir port and reverse scrolling).
module helo_scroll_ctrl
  import helo_pkg::*;
#(
  parameter int unsigned DIV = 25_000_000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       run,
  input  logic       step,
`ifdef SCROLL_DIR_EN
  input  logic       dir,
`endif
  output logic [2:0] sel,
  output logic [0:6] HEX4,
  output logic [0:6] HEX3,
  output logic [0:6] HEX2,
  output logic [0:6] HEX1,
  output logic [0:6] HEX0
);

  localparam int unsigned CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic             step_q;
  logic             rev;
  logic             wrap;
  logic             step_adv;
  logic             advance;

`ifdef SCROLL_DIR_EN
  assign rev = dir;
`else
  assign rev = 1'b0;
`endif

  always_comb begin
    wrap     = run && (cnt == CNT_LAST);
    step_adv = step && !step_q && !run;
    advance  = wrap || step_adv;
  end

  // step_q follows step even while running, so a step held high across a
  // run 1->0 transition is not mistaken for a fresh press.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      cnt    <= '0;
      step_q <= 1'b0;
      sel    <= 3'd0;
    end else begin
      step_q <= step;
      if (run) begin
        cnt <= wrap ? '0 : cnt + CNT_W'(1);
      end
      if (advance) begin
        sel <= next_sel(sel, rev);
      end
    end
  end

  char_t code4, code3, code2, code1, code0;

  always_comb begin
    code4 = msg_char(rot_idx(sel, 3'd0));
    code3 = msg_char(rot_idx(sel, 3'd1));
    code2 = msg_char(rot_idx(sel, 3'd2));
    code1 = msg_char(rot_idx(sel, 3'd3));
    code0 = msg_char(rot_idx(sel, 3'd4));
  end

  helo_seg_decoder u_dec4 (.code(code4), .seg(HEX4));
  helo_seg_decoder u_dec3 (.code(code3), .seg(HEX3));
  helo_seg_decoder u_dec2 (.code(code2), .seg(HEX2));
  helo_seg_decoder u_dec1 (.code(code1), .seg(HEX1));
  helo_seg_decoder u_dec0 (.code(code0), .seg(HEX0));

endmodule

// File: tb/tb_helo_scroll_ctrl.sv
// tb_helo_scroll_ctrl: scoreboard bench for helo_scroll_ctrl with DIV=4.
// Stimulus is applied on the falling edge and the reference model's
// post-edge state is queued; a monitor checks sel and all digits just after
// each rising edge.
module tb_helo_scroll_ctrl;

  localparam int unsigned DIV = 4;

  logic       clk;
  logic       reset;
  logic       run;
  logic       step;
  logic       dir;
  logic [2:0] sel;
  logic [0:6] hex4, hex3, hex2, hex1, hex0;

  helo_scroll_ctrl #(.DIV(DIV)) dut (
    .CLOCK_50(clk),
    .reset(reset),
    .run(run),
    .step(step),
`ifdef SCROLL_DIR_EN
    .dir(dir),
`endif
    .sel(sel),
    .HEX4(hex4),
    .HEX3(hex3),
    .HEX2(hex2),
    .HEX1(hex1),
    .HEX0(hex0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int    pos;
    string tag;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   done    = 1'b0;

  // Reference model: position in the message, enabled-cycle count, last step.
  int m_pos      = 0;
  int m_enabled  = 0;
  bit m_prev_stp = 1'b0;

  string msg = "HELLO";

  function automatic logic [6:0] seg_of(input byte c);
    logic [6:0] s;
    case (c)
      "H":     s = 7'b1001000;
      "E":     s = 7'b0110000;
      "L":     s = 7'b1110001;
      "O":     s = 7'b0000001;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  function automatic logic [34:0] hex_of(input int pos);
    logic [34:0] v;
    v = '0;
    for (int k = 4; k >= 0; k--) begin
      v = {v[27:0], seg_of(msg[(pos + 4 - k) % 5])};
    end
    return v;
  endfunction

  task automatic drive(input bit r, input bit ru, input bit st, input bit d, input string tag);
    bit   rev;
    bit   adv;
    exp_t e;
    @(negedge clk);
    reset = r;
    run   = ru;
    step  = st;
    dir   = d;
`ifdef SCROLL_DIR_EN
    rev = d;
`else
    rev = 1'b0;
`endif
    if (r) begin
      m_pos      = 0;
      m_enabled  = 0;
      m_prev_stp = 1'b0;
    end else begin
      adv = 1'b0;
      if (ru) begin
        m_enabled = (m_enabled + 1) % DIV;
        adv = (m_enabled == 0);
      end else if (st && !m_prev_stp) begin
        adv = 1'b1;
      end
      m_prev_stp = st;
      if (adv) m_pos = rev ? (m_pos + 4) % 5 : (m_pos + 1) % 5;
    end
    e.pos = m_pos;
    e.tag = tag;
    q.push_back(e);
  endtask

  // Monitor
  initial begin
    exp_t        e;
    logic [34:0] want_hex;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        want_hex = hex_of(e.pos);
        n_tests++;
        if (sel !== 3'(e.pos)) begin
          n_fail++;
          $display("FAIL %s sel: got %0d expected %0d", e.tag, sel, e.pos);
        end
        n_tests++;
        if ({hex4, hex3, hex2, hex1, hex0} !== want_hex) begin
          n_fail++;
          $display("FAIL %s hex: got %b expected %b", e.tag,
                   {hex4, hex3, hex2, hex1, hex0}, want_hex);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    run   = 1'b0;
    step  = 1'b0;
    dir   = 1'b0;

    repeat (2) drive(1, 0, 0, 0, "reset");

    repeat (20) drive(0, 1, 0, 0, "auto");

    drive(1, 0, 0, 0, "pause_rst");
    repeat (2)  drive(0, 1, 0, 0, "pause_run");
    repeat (10) drive(0, 0, 0, 0, "pause_hold");
    repeat (4)  drive(0, 1, 0, 0, "resume");

    drive(1, 0, 0, 0, "step_rst");
    repeat (5) drive(0, 0, 1, 0, "step_hold");
    drive(0, 0, 0, 0, "step_low");
    repeat (2) drive(0, 0, 1, 0, "step_again");
    drive(0, 0, 0, 0, "step_low2");
    for (int i = 0; i < 8; i++) drive(0, 1, i[0], 0, "step_while_run");
    drive(0, 1, 1, 0, "step_high_run");
    repeat (3) drive(0, 0, 1, 0, "run_fall_step_high");
    drive(0, 0, 0, 0, "step_release");

    drive(1, 0, 0, 0, "midop_rst");
    repeat (14) drive(0, 1, 0, 0, "midop_run");
    drive(1, 1, 0, 0, "midop_reset_pulse");
    repeat (8) drive(0, 1, 0, 0, "midop_after");

    drive(1, 0, 0, 1, "dir_rst");
    repeat (8) drive(0, 1, 0, 1, "dir_rev");
    repeat (3) drive(0, 0, 1, 1, "dir_step");

    for (int i = 0; i < 500; i++) begin
      drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) != 0),
            $urandom_range(0, 1), $urandom_range(0, 1), "random");
    end

    repeat (3) @(posedge clk);
    #2;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
